// File: rtl/palette_pkg.sv
// Shared constants and types for the runtime-writable, double-buffered colour palette.
package palette_pkg;
  localparam int FADE_W   = 5;
  localparam int FADE_MAX = 16;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    COPY
  } state_t;

  // Element 0 is the least-significant slice; each colour is {R,G,B} at 8 bits per channel.
  localparam logic [15:0][23:0] DEFAULT_PALETTE = {
    24'hb2dcef, 24'h31a2f2, 24'h005784, 24'h1b2632,
    24'ha3ce27, 24'h44891a, 24'h2f484e, 24'hf7e26b,
    24'heb8931, 24'ha46422, 24'h493c2b, 24'he06f8b,
    24'hbe2633, 24'hffffff, 24'h9d9d9d, 24'h000000
  };
endpackage

// File: rtl/palette_bank_ram.sv
// One palette bank: a single write port plus registered lookup and copy read ports.
// The copy port forwards same-edge write data so a write landing on the swap edge is copied too.
module palette_bank_ram #(
  parameter int IDX_W = 4,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0] look_addr,
  output logic [WIDTH-1:0] look_data,
  input  logic [IDX_W-1:0] copy_addr,
  output logic [WIDTH-1:0] copy_data
);
  localparam int DEPTH = 2**IDX_W;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    look_data <= mem[look_addr];
    copy_data <= (we && (waddr == copy_addr)) ? wdata : mem[copy_addr];
  end
endmodule

// File: rtl/palette_lut.sv
// Double-buffered colour LUT: writes go to a shadow bank, a commit swaps banks at the next frame
// start, and lookups pass through a fixed two-stage read + fade pipeline.
module palette_lut
  import palette_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int CH_W  = 8
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [IDX_W-1:0]  idx_in,
  input  logic              valid_in,
  output logic [3*CH_W-1:0] color_out,
  output logic              valid_out,
  input  logic [FADE_W-1:0] fade_in,
  input  logic              wr_valid_in,
  output logic              wr_ready_out,
  input  logic [IDX_W-1:0]  wr_idx_in,
  input  logic [3*CH_W-1:0] wr_color_in,
  input  logic              commit_in,
  input  logic              frame_start_in,
  output logic              commit_pending_out,
  output logic              busy_out
);
  localparam int DEPTH = 2**IDX_W;
  localparam int COL_W = 3*CH_W;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [FADE_W-1:0] FADE_SAT = FADE_W'(FADE_MAX);

  state_t           state;
  logic [IDX_W-1:0] cnt;
  logic             active;
  logic             shadow;
  logic             pending;
  logic             swap;

  logic [1:0]       bank_we;
  logic [IDX_W-1:0] bank_waddr;
  logic [COL_W-1:0] bank_wdata;
  logic [IDX_W-1:0] copy_addr;
  logic [COL_W-1:0] look_data [2];
  logic [COL_W-1:0] copy_data [2];

  logic              sel_q;
  logic              init_q;
  logic              v1_q;
  logic [FADE_W-1:0] fade_q;
  logic [COL_W-1:0]  s1_color;
  logic [COL_W-1:0]  faded;
  logic [CH_W+4:0]   prod;

  // Top CH_W bits of each 8-bit channel, zero-padded below when CH_W exceeds 8.
  function automatic logic [COL_W-1:0] scale_color(input logic [23:0] c);
    logic [CH_W+7:0] t;
    scale_color = '0;
    for (int k = 0; k < 3; k++) begin
      t = {c[k*8 +: 8], {CH_W{1'b0}}};
      scale_color[k*CH_W +: CH_W] = t[CH_W+7 -: CH_W];
    end
  endfunction

  for (genvar b = 0; b < 2; b++) begin : g_bank
    palette_bank_ram #(.IDX_W(IDX_W), .WIDTH(COL_W)) u_ram (
      .clk       (clk_in),
      .we        (bank_we[b]),
      .waddr     (bank_waddr),
      .wdata     (bank_wdata),
      .look_addr (idx_in),
      .look_data (look_data[b]),
      .copy_addr (copy_addr),
      .copy_data (copy_data[b])
    );
  end

  // Write handshake: a write transfers on a rising edge where wr_valid_in and wr_ready_out are
  // both high; wr_ready_out depends only on the state, never on wr_valid_in.
  assign shadow             = ~active;
  assign swap               = (state == IDLE) && frame_start_in && (pending || commit_in);
  assign wr_ready_out       = (state == IDLE);
  assign busy_out           = (state != IDLE);
  assign commit_pending_out = pending;
  // Copy reads run one entry ahead of the shadow writes, starting on the swap edge.
  assign copy_addr          = (state == COPY) ? cnt + 1'b1 : '0;

  always_comb begin
    bank_we    = '0;
    bank_waddr = cnt;
    bank_wdata = scale_color(DEFAULT_PALETTE[4'(cnt)]);
    case (state)
      INIT: bank_we = 2'b11;
      IDLE: begin
        bank_waddr      = wr_idx_in;
        bank_wdata      = wr_color_in;
        bank_we[shadow] = wr_valid_in;
      end
      COPY: begin
        bank_wdata      = copy_data[active];
        bank_we[shadow] = 1'b1;
      end
      default: bank_we = '0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state   <= INIT;
      cnt     <= '0;
      active  <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (swap) pending <= 1'b0;
      else if (commit_in) pending <= 1'b1;
      case (state)
        INIT, COPY: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_IDX) state <= IDLE;
        end
        IDLE: begin
          if (swap) begin
            active <= ~active;
            state  <= COPY;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  assign s1_color = init_q ? '0 : look_data[sel_q];

  always_comb begin
    faded = '0;
    prod  = '0;
    for (int k = 0; k < 3; k++) begin
      prod = {5'b0, s1_color[k*CH_W +: CH_W]} * {{CH_W{1'b0}}, fade_q};
      faded[k*CH_W +: CH_W] = prod[CH_W+3:4];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sel_q     <= 1'b0;
      init_q    <= 1'b1;
      v1_q      <= 1'b0;
      fade_q    <= '0;
      color_out <= '0;
      valid_out <= 1'b0;
    end else begin
      sel_q     <= active;
      init_q    <= (state == INIT);
      v1_q      <= valid_in;
      fade_q    <= (fade_in > FADE_SAT) ? FADE_SAT : fade_in;
      color_out <= faded;
      valid_out <= v1_q;
    end
  end
endmodule

// File: tb/tb_palette_lut.sv
// Bench for palette_lut: fixed lookup vectors, directed commit/swap/reset sequences, and random
// traffic checked against a bank-level reference model.
module tb_palette_lut;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  idx_in = '0;
  logic        valid_in = 1'b0;
  logic [23:0] color_out;
  logic        valid_out;
  logic [4:0]  fade_in = 5'd16;
  logic        wr_valid_in = 1'b0;
  logic        wr_ready_out;
  logic [3:0]  wr_idx_in = '0;
  logic [23:0] wr_color_in = '0;
  logic        commit_in = 1'b0;
  logic        frame_start_in = 1'b0;
  logic        commit_pending_out;
  logic        busy_out;

  palette_lut #(.IDX_W(4), .CH_W(8)) dut (
    .clk_in             (clk),
    .rst_n_in           (rst_n),
    .idx_in             (idx_in),
    .valid_in           (valid_in),
    .color_out          (color_out),
    .valid_out          (valid_out),
    .fade_in            (fade_in),
    .wr_valid_in        (wr_valid_in),
    .wr_ready_out       (wr_ready_out),
    .wr_idx_in          (wr_idx_in),
    .wr_color_in        (wr_color_in),
    .commit_in          (commit_in),
    .frame_start_in     (frame_start_in),
    .commit_pending_out (commit_pending_out),
    .busy_out           (busy_out)
  );

  // ---- clock / watchdog ----
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // ---- scoreboard ----
  int n_cmp = 0;
  int n_err = 0;
  logic [24:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---- reference model: two banks, active pointer, pending flag, busy countdown ----
  logic [23:0] def_pal [16];
  logic [23:0] bank_m [2][16];
  int          m_active;
  int          m_busy;
  bit          m_init;
  bit          m_pend;

  function automatic logic [23:0] fade_model(input logic [23:0] c, input logic [4:0] f);
    int fs;
    logic [23:0] r;
    r = '0;
    fs = (f > 5'd16) ? 16 : int'(f);
    for (int k = 0; k < 3; k++) r[k*8 +: 8] = 8'((int'(c[k*8 +: 8]) * fs) / 16);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      bank_m[0][i] = def_pal[i];
      bank_m[1][i] = def_pal[i];
    end
    m_active = 0;
    m_busy   = DEPTH;
    m_init   = 1'b1;
    m_pend   = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    if (m_busy > 0) begin
      if (commit_in) m_pend = 1'b1;
      m_busy--;
      if (m_busy == 0) m_init = 1'b0;
    end else begin
      if (wr_valid_in) bank_m[1-m_active][wr_idx_in] = wr_color_in;
      if (frame_start_in && (m_pend || commit_in)) begin
        m_active = 1 - m_active;
        for (int i = 0; i < 16; i++) bank_m[1-m_active][i] = bank_m[m_active][i];
        m_pend = 1'b0;
        m_busy = DEPTH;
      end else if (commit_in) begin
        m_pend = 1'b1;
      end
    end
  endtask

  // ---- driver tasks ----
  task automatic tick();
    logic [24:0] e;
    logic [23:0] c;
    c = (m_busy > 0 && m_init) ? 24'h0 : fade_model(bank_m[m_active][idx_in], fade_in);
    exp_q.push_back({valid_in, c});
    model_edge();
    @(posedge clk);
    #1;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      check("valid_out", valid_out, e[24]);
      check("color_out", color_out, e[23:0]);
    end
    check("busy_out", busy_out, m_busy > 0);
    check("wr_ready_out", wr_ready_out, m_busy == 0);
    check("commit_pending_out", commit_pending_out, m_pend);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_color_out", color_out, 0);
    check("rst_valid_out", valid_out, 0);
    check("rst_busy_out", busy_out, 1);
    check("rst_wr_ready_out", wr_ready_out, 0);
    check("rst_commit_pending", commit_pending_out, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int guard = 0;
    while (busy_out && guard < 100) begin
      tick();
      guard++;
    end
    check({name, "_idle_reached"}, busy_out, 0);
  endtask

  task automatic lookup_check(input string name, input logic [3:0] i, input logic [4:0] f,
                              input logic [23:0] exp);
    idx_in = i;
    fade_in = f;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick();
    check(name, color_out, exp);
    check({name, "_valid"}, valid_out, 1);
  endtask

  // ---- directed vectors ----
  typedef struct {
    logic [3:0]  idx;
    logic [4:0]  fade;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int busy_cnt;
    int g;
    logic pend_seen;

    def_pal = '{24'h000000, 24'h9d9d9d, 24'hffffff, 24'hbe2633,
                24'he06f8b, 24'h493c2b, 24'ha46422, 24'heb8931,
                24'hf7e26b, 24'h2f484e, 24'h44891a, 24'ha3ce27,
                24'h1b2632, 24'h005784, 24'h31a2f2, 24'hb2dcef};
    vecs[0] = '{4'd3,  5'd16, 24'hbe2633};
    vecs[1] = '{4'd15, 5'd16, 24'hb2dcef};
    vecs[2] = '{4'd2,  5'd8,  24'h7f7f7f};
    vecs[3] = '{4'd2,  5'd0,  24'h000000};
    vecs[4] = '{4'd2,  5'd31, 24'hffffff};
    vecs[5] = '{4'd5,  5'd16, 24'h493c2b};
    vecs[6] = '{4'd1,  5'd4,  24'h272727};
    vecs[7] = '{4'd7,  5'd12, 24'hb06624};
    vecs[8] = '{4'd14, 5'd17, 24'h31a2f2};

    #2 apply_reset();
    // lookups during INIT must read as zero
    idx_in = 4'd2;
    valid_in = 1'b1;
    wait_idle("init");
    valid_in = 1'b0;

    for (int i = 0; i < 9; i++) lookup_check($sformatf("vec%0d", i), vecs[i].idx, vecs[i].fade, vecs[i].exp);

    // write without commit stays invisible, commit + frame start swaps
    fade_in = 5'd16;
    wr_valid_in = 1'b1; wr_idx_in = 4'd3; wr_color_in = 24'h123456;
    tick();
    wr_valid_in = 1'b0;
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    check("no_commit_no_swap", busy_out, 0);
    lookup_check("no_commit_keeps_old", 4'd3, 5'd16, 24'hbe2633);
    commit_in = 1'b1;
    tick();
    commit_in = 1'b0;
    check("commit_pending_set", commit_pending_out, 1);
    frame_start_in = 1'b1; valid_in = 1'b1; idx_in = 4'd3;
    tick();
    frame_start_in = 1'b0;
    busy_cnt = busy_out ? 1 : 0;
    check("swap_clears_pending", commit_pending_out, 0);
    tick();
    busy_cnt += busy_out ? 1 : 0;
    check("swap_cycle_lookup_old", color_out, 24'hbe2633);
    valid_in = 1'b0;
    tick();
    busy_cnt += busy_out ? 1 : 0;
    check("post_swap_lookup_new", color_out, 24'h123456);
    g = 0;
    while (busy_out && g < 40) begin
      tick();
      if (busy_out) busy_cnt++;
      g++;
    end
    check("copy_busy_cycles", busy_cnt, DEPTH);

    // same-cycle commit and frame start; write held through COPY
    commit_in = 1'b1; frame_start_in = 1'b1;
    tick();
    commit_in = 1'b0; frame_start_in = 1'b0;
    check("same_cycle_swap_busy", busy_out, 1);
    pend_seen = commit_pending_out;
    wr_valid_in = 1'b1; wr_idx_in = 4'd9; wr_color_in = 24'h0a0b0c;
    g = 0;
    while (busy_out && g < 40) begin
      check("copy_ready_low", wr_ready_out, 0);
      tick();
      pend_seen |= commit_pending_out;
      g++;
    end
    check("copy_done", busy_out, 0);
    tick();
    wr_valid_in = 1'b0;
    check("pending_never_set", pend_seen, 0);

    // commit and frame start while busy: pending survives until an IDLE frame start
    commit_in = 1'b1; frame_start_in = 1'b1;
    tick();
    commit_in = 1'b0; frame_start_in = 1'b0;
    lookup_check("held_write_visible", 4'd9, 5'd16, 24'h0a0b0c);
    commit_in = 1'b1;
    tick();
    commit_in = 1'b0;
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    check("busy_frame_keeps_pending", commit_pending_out, 1);
    check("busy_frame_still_busy", busy_out, 1);
    wait_idle("pend");
    check("pending_after_copy", commit_pending_out, 1);
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    check("idle_frame_swaps", busy_out, 1);
    check("idle_frame_clears", commit_pending_out, 0);
    wait_idle("pend2");

    // reset in the middle of COPY discards runtime writes
    wr_valid_in = 1'b1; wr_idx_in = 4'd5; wr_color_in = 24'habcdef;
    tick();
    wr_valid_in = 1'b0;
    commit_in = 1'b1; frame_start_in = 1'b1;
    tick();
    commit_in = 1'b0; frame_start_in = 1'b0;
    idx_in = 4'd5; valid_in = 1'b1;
    repeat (3) tick();
    check("pre_reset_color", color_out, 24'habcdef);
    check("pre_reset_busy", busy_out, 1);
    #2 apply_reset();
    idx_in = 4'd2;
    valid_in = 1'b1;
    wait_idle("reinit");
    valid_in = 1'b0;
    lookup_check("reset_restores_default", 4'd5, 5'd16, 24'h493c2b);

    // random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      valid_in       = 1'($urandom_range(0, 1));
      idx_in         = 4'($urandom_range(0, 15));
      fade_in        = 5'($urandom_range(0, 31));
      wr_valid_in    = ($urandom_range(0, 2) == 0);
      wr_idx_in      = 4'($urandom_range(0, 15));
      wr_color_in    = 24'($urandom);
      commit_in      = ($urandom_range(0, 15) == 0);
      frame_start_in = ($urandom_range(0, 11) == 0);
      tick();
    end
    valid_in = 1'b0; wr_valid_in = 1'b0; commit_in = 1'b0; frame_start_in = 1'b0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/palette_lut.md
Name: palette_lut

Overview:
- Runtime-writable, double-buffered colour lookup table; generalised successor to the fixed 16-entry palette.
- Maps a pixel index to an RGB colour with a fixed 2-cycle pipeline and applies a global fade (brightness) factor.
- Sits between the sprite/tile index generator and the video output stage.
- CPU-side writes go to a shadow bank; a commit request swaps banks on the next frame boundary, so no colour changes mid-frame.

Parameters:
- IDX_W, 4, index width; DEPTH = 2**IDX_W entries per bank.
- CH_W, 8, bits per colour channel; the colour word is 3*CH_W bits, ordered {R,G,B}.

Ports:
- clk_in  input  1  pixel clock.
- rst_n_in  input  1  asynchronous reset, active-low.
- idx_in  input  IDX_W  lookup index.
- valid_in  input  1  idx_in is valid this cycle.
- color_out  output  3*CH_W  faded colour.
- valid_out  output  1  color_out is valid; equals valid_in delayed by 2 cycles.
- fade_in  input  5  brightness 0..16; values above 16 saturate to 16.
- wr_valid_in  input  1  write request to the shadow bank.
- wr_ready_out  output  1  write accepted when wr_valid_in and wr_ready_out are both high.
- wr_idx_in  input  IDX_W  write address.
- wr_color_in  input  3*CH_W  write data.
- commit_in  input  1  one-cycle pulse requesting a bank swap.
- frame_start_in  input  1  one-cycle pulse at the frame boundary.
- commit_pending_out  output  1  a commit is latched and not yet applied.
- busy_out  output  1  state machine is in INIT or COPY.

Behaviour:
Reset (rst_n_in low, asynchronous):
- color_out=0, valid_out=0, wr_ready_out=0, commit_pending_out=0, busy_out=1.
- Active bank = bank 0; state = INIT; counter = 0.

State machine:
- INIT: one entry per cycle, write entry i of both banks with DEFAULT_PALETTE[i mod 16], scaled to CH_W. Scaling: take the top CH_W bits of each 8-bit channel, or zero-pad the LSBs if CH_W > 8. After DEPTH cycles go to IDLE.
- IDLE: wr_ready_out=1, busy_out=0. An accepted write updates shadow[wr_idx_in]. A write to the same index later in the same frame overwrites the earlier one.
- COPY: entered on the cycle after a swap. Copies active[i] into shadow[i] for i=0..DEPTH-1, one per cycle (DEPTH cycles total), then returns to IDLE. wr_ready_out=0 throughout COPY and INIT.

Commit and swap:
- commit_in sets the pending flag in any state.
- A swap occurs on a frame_start_in cycle only when state==IDLE and either the pending flag is set or commit_in is high in that same cycle.
- On swap: toggle the active bank, clear the pending flag, enter COPY.
- If frame_start_in arrives while busy: no swap; the pending flag is kept for the next frame_start_in.
- A write accepted in the same cycle as the swap lands in the old shadow bank, which becomes active, so it takes effect immediately.
- Repeated commit_in pulses before a swap collapse into one pending flag.

Lookup pipeline (latency 2, no stalls):
- Stage 1: registered read of active[idx_in]. A swap at cycle t affects lookups presented at cycle t+1 and later. During INIT, the stage-1 data is forced to 0.
- Stage 2: each channel out = (ch * fade_sat) >> 4, with an (CH_W+5)-bit intermediate, truncated to CH_W. fade_sat is fade_in registered in stage 1 and saturated at 16, so fade=16 passes the colour unchanged.
- color_out is updated every cycle regardless of valid_in; valid_out qualifies it.

Reset mid-operation: asserting rst_n_in during COPY or INIT aborts immediately and restarts INIT. Shadow writes made before the reset are lost.

Decomposition:
- palette_pkg:
  - DEFAULT_PALETTE: 16×24-bit constant (0=000000, 1=9d9d9d, 2=ffffff, 3=be2633, 4=e06f8b, 5=493c2b, 6=a46422, 7=eb8931, 8=f7e26b, 9=2f484e, 10=44891a, 11=a3ce27, 12=1b2632, 13=005784, 14=31a2f2, 15=b2dcef).
  - FADE_W=5, FADE_MAX=16.
  - State enum {INIT, IDLE, COPY}.
- Sub-module palette_bank_ram: DEPTH×3*CH_W, one write port, two registered read ports (lookup and copy), distributed RAM. Instantiated twice.

Test Plan:
- Release reset, wait until busy_out=0; look up idx 3 and 15 with fade=16 → color_out=0xbe2633 and 0xb2dcef exactly 2 cycles after valid_in; valid_out aligned.
- Write idx 3 = 0x123456, no commit, pulse frame_start → lookup still 0xbe2633; then pulse commit, then frame_start → 0x123456 from the next cycle; busy_out high for exactly DEPTH=16 cycles.
- fade=8 on idx 2 → 0x7f7f7f; fade=0 → 0x000000; fade=31 → 0xffffff (saturated).
- Commit while in COPY, then frame_start during COPY → no swap and commit_pending_out stays 1; the next frame_start in IDLE swaps.
- Same-cycle commit_in and frame_start_in in IDLE → immediate swap, commit_pending_out never asserts. During COPY, wr_valid_in is held, wr_ready_out=0, and the write is accepted in the first IDLE cycle.
- Assert rst_n_in low mid-COPY after writing idx 5 = 0xabcdef → outputs clear asynchronously; after INIT, idx 5 reads 0x493c2b.
